rca_use_sequencer: RTL and testbench

- Controller between the RCA issue path and the RCA grid.
- Accepts RCA use requests in order, selects and switches the active RCA, and sequences grid flush when switching.
- Pushes operand-valid strobes to the grid and tracks in-flight uses with an in-order tag FIFO.
- Drives the writeback handshake: done, id, fb flag and commit/pop. Stalls config writes that would corrupt in-flight work.

---
 rtl/rca_use_sequencer.sv | 140 ++++++++++++++
 tb/tb_rca_use_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_use_sequencer.sv
// Sequences RCA use requests onto the grid: selects the running RCA, flushes the grid on a switch,
// and tracks in-flight uses in order so results can be written back with their id and fb flag.
module rca_use_sequencer #(
    parameter int unsigned NUM_RCAS     = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned ID_W         = 3,
    localparam int unsigned SEL_W       = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
    localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_rca_sel,
    input  logic [ID_W-1:0]  req_id,
    input  logic             req_fb,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_rca_sel,
    output logic             cfg_ready,
    output logic [SEL_W-1:0] currently_running_rca,
    output logic             buf_data_valid,
    output logic             clear_fifos,
    input  logic             fifo_populated,
    output logic             wb_done,
    output logic [ID_W-1:0]  wb_id,
    output logic             wb_fb_instr,
    input  logic             wb_ack,
    output logic             wb_committing,
    output logic [CNT_W-1:0] inflight
);

    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned TAG_W = ID_W + 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [SEL_W-1:0] r_rca;
    logic             r_dirty;
    logic             r_buf_valid;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [TAG_W-1:0] r_tags [MAX_INFLIGHT];

    logic             w_empty;
    logic             w_accept;
    logic             w_commit;
    logic             w_switch;
    logic             w_enter_clear;
    logic             w_cfg_grant;
    logic [TAG_W-1:0] w_head;

    assign w_empty  = (r_count == '0);
    assign w_head   = r_tags[r_rd_ptr];
    assign w_switch = (r_state == S_RUN) && req_valid &&
                      ((req_rca_sel != r_rca) || r_dirty);

    assign req_ready = (r_state == S_RUN) && !r_dirty && (req_rca_sel == r_rca) &&
                       (r_count < CNT_W'(MAX_INFLIGHT));
    assign w_accept  = req_valid && req_ready;

    assign wb_done       = !w_empty && fifo_populated && (r_state != S_CLEAR);
    assign wb_id         = w_empty ? '0 : w_head[TAG_W-1:1];
    assign wb_fb_instr   = !w_empty && w_head[0];
    assign wb_committing = wb_done && wb_ack;
    assign w_commit      = wb_committing;

    // Writes to the running RCA wait until nothing of its old config is left in the grid.
    assign cfg_ready   = !((cfg_rca_sel == r_rca) && (!w_empty || (r_state == S_DRAIN)));
    assign w_cfg_grant = cfg_valid && cfg_ready && (cfg_rca_sel == r_rca);

    assign currently_running_rca = r_rca;
    assign buf_data_valid        = r_buf_valid;
    assign clear_fifos           = (r_state == S_CLEAR);
    assign inflight              = r_count;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_switch) w_state_nxt = w_empty ? S_CLEAR : S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_clr_cnt == CLR_W'(1)) w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    assign w_enter_clear = (w_state_nxt == S_CLEAR) && (r_state != S_CLEAR);

    // Flush timer, RCA selection and stale-config tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= CLR_W'(CLEAR_CYCLES);
            r_rca     <= '0;
            r_dirty   <= 1'b0;
        end else begin
            if (w_enter_clear) begin
                r_clr_cnt <= CLR_W'(CLEAR_CYCLES);
                r_rca     <= req_rca_sel;
                r_dirty   <= 1'b0;
            end else if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt - CLR_W'(1);
            end
            if (w_cfg_grant) r_dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_buf_valid <= w_accept;
            if (w_accept && !w_commit)      r_count <= r_count + CNT_W'(1);
            else if (!w_accept && w_commit) r_count <= r_count - CNT_W'(1);
            if (w_accept)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_commit)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_tags[r_wr_ptr] <= {req_id, req_fb};
    end

endmodule

// File: tb/tb_rca_use_sequencer.sv
// Self-checking bench for rca_use_sequencer: directed scenarios plus an in-order
// writeback scoreboard fed by accepted requests.
module tb_rca_use_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_rca_sel;
    logic [2:0] req_id;
    logic       req_fb;
    logic       cfg_valid;
    logic [1:0] cfg_rca_sel;
    logic       cfg_ready;
    logic [1:0] currently_running_rca;
    logic       buf_data_valid;
    logic       clear_fifos;
    logic       fifo_populated;
    logic       wb_done;
    logic [2:0] wb_id;
    logic       wb_fb_instr;
    logic       wb_ack;
    logic       wb_committing;
    logic [2:0] inflight;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb[$];

    rca_use_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rca_sel(req_rca_sel),
        .req_id(req_id), .req_fb(req_fb),
        .cfg_valid(cfg_valid), .cfg_rca_sel(cfg_rca_sel), .cfg_ready(cfg_ready),
        .currently_running_rca(currently_running_rca), .buf_data_valid(buf_data_valid),
        .clear_fifos(clear_fifos), .fifo_populated(fifo_populated),
        .wb_done(wb_done), .wb_id(wb_id), .wb_fb_instr(wb_fb_instr),
        .wb_ack(wb_ack), .wb_committing(wb_committing), .inflight(inflight)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: accepted tags go in, committed tags must come out in the same order.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) sb.push_back({req_id, req_fb});
            if (wb_committing) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_commit: got id=%0d fb=%0d, required nothing outstanding", wb_id, wb_fb_instr);
                end else begin
                    logic [3:0] exp;
                    exp = sb.pop_front();
                    if ({wb_id, wb_fb_instr} !== exp) begin
                        n_err++;
                        $display("FAIL sb_commit: got id=%0d fb=%0d, required id=%0d fb=%0d",
                                 wb_id, wb_fb_instr, exp[3:1], exp[0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] sel, input logic [2:0] id, input logic fb, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1; req_rca_sel = sel; req_id = id; req_fb = fb;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (req_ready) ok = 1'b1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain_all(output bit ok);
        fifo_populated = 1'b1; wb_ack = 1'b1;
        for (int i = 0; i < 20 && inflight != 3'd0; i++) tick();
        ok = (inflight == 3'd0);
        fifo_populated = 1'b0; wb_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_rca_sel = 2'd0; req_id = '0; req_fb = 1'b0;
        cfg_valid = 1'b0; cfg_rca_sel = 2'd0; fifo_populated = 1'b0; wb_ack = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({inflight, buf_data_valid, clear_fifos, currently_running_rca, wb_done} !== {3'd0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got inflight=%0d bdv=%0d clr=%0d rca=%0d done=%0d, required 0 0 1 0 0",
                     inflight, buf_data_valid, clear_fifos, currently_running_rca, wb_done);
        end
        rst = 1'b0; req_valid = 1'b1; req_id = 3'd5;
        #1;
        n_cmp++;
        if (clear_fifos !== 1'b1 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL clear_cycle1: got clr=%0d rdy=%0d, required clr=1 rdy=0", clear_fifos, req_ready);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b1 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL clear_cycle2: got clr=%0d rdy=%0d, required clr=1 rdy=0", clear_fifos, req_ready);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL run_cycle3: got clr=%0d rdy=%0d, required clr=0 rdy=1", clear_fifos, req_ready);
        end
    endtask

    task automatic test_single();
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (buf_data_valid !== 1'b1 || inflight !== 3'd1) begin
            n_err++; $display("FAIL single_accept: got bdv=%0d inflight=%0d, required 1 1", buf_data_valid, inflight);
        end
        tick();
        fifo_populated = 1'b1;
        #1;
        n_cmp++;
        if (buf_data_valid !== 1'b0 || wb_done !== 1'b1 || wb_id !== 3'd5) begin
            n_err++; $display("FAIL single_done: got bdv=%0d done=%0d id=%0d, required 0 1 5", buf_data_valid, wb_done, wb_id);
        end
        wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (wb_committing !== 1'b1) begin
            n_err++; $display("FAIL single_commit: got %0d, required 1", wb_committing);
        end
        tick();
        wb_ack = 1'b0; fifo_populated = 1'b0;
        n_cmp++;
        if (inflight !== 3'd0 || wb_done !== 1'b0) begin
            n_err++; $display("FAIL single_pop: got inflight=%0d done=%0d, required 0 0", inflight, wb_done);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        req_rca_sel = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_id = 3'(i); req_fb = 1'(i);
            #1;
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready%0d: got %0d, required 1", i, req_ready);
            end
            tick();
            n_cmp++;
            if (buf_data_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b_strobe%0d: got %0d, required 1", i, buf_data_valid);
            end
        end
        req_id = 3'd5; req_fb = 1'b0; fifo_populated = 1'b1; wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (inflight !== 3'd4 || req_ready !== 1'b0 || wb_id !== 3'd1 || wb_committing !== 1'b1) begin
            n_err++; $display("FAIL full_no_bypass: got inflight=%0d rdy=%0d id=%0d com=%0d, required 4 0 1 1",
                              inflight, req_ready, wb_id, wb_committing);
        end
        tick();
        n_cmp++;
        if (inflight !== 3'd3 || req_ready !== 1'b1 || wb_id !== 3'd2) begin
            n_err++; $display("FAIL after_pop: got inflight=%0d rdy=%0d id=%0d, required 3 1 2", inflight, req_ready, wb_id);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (inflight !== 3'd3 || buf_data_valid !== 1'b1) begin
            n_err++; $display("FAIL fifth_accept: got inflight=%0d bdv=%0d, required 3 1", inflight, buf_data_valid);
        end
        drain_all(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL b2b_drain: got inflight=%0d, required 0", inflight);
        end
    endtask

    task automatic test_switch();
        bit ok1, ok2;
        send(2'd0, 3'd6, 1'b1, ok1);
        send(2'd0, 3'd7, 1'b0, ok2);
        n_cmp++;
        if (!ok1 || !ok2 || inflight !== 3'd2) begin
            n_err++; $display("FAIL sw_setup: got ok=%0d%0d inflight=%0d, required 11 2", ok1, ok2, inflight);
        end
        req_valid = 1'b1; req_rca_sel = 2'd2; req_id = 3'd1; req_fb = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++; $display("FAIL sw_not_ready: got %0d, required 0", req_ready);
        end
        tick();
        fifo_populated = 1'b1; wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0 || clear_fifos !== 1'b0 || currently_running_rca !== 2'd0 || wb_committing !== 1'b1) begin
            n_err++; $display("FAIL drain_state: got rdy=%0d clr=%0d rca=%0d com=%0d, required 0 0 0 1",
                              req_ready, clear_fifos, currently_running_rca, wb_committing);
        end
        tick(); tick();
        fifo_populated = 1'b0; wb_ack = 1'b0;
        #1;
        n_cmp++;
        if (inflight !== 3'd0 || req_ready !== 1'b0 || clear_fifos !== 1'b0) begin
            n_err++; $display("FAIL drain_done: got inflight=%0d rdy=%0d clr=%0d, required 0 0 0", inflight, req_ready, clear_fifos);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b1 || currently_running_rca !== 2'd2) begin
            n_err++; $display("FAIL sw_clear1: got clr=%0d rca=%0d, required 1 2", clear_fifos, currently_running_rca);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b1) begin
            n_err++; $display("FAIL sw_clear2: got clr=%0d, required 1", clear_fifos);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL sw_run: got clr=%0d rdy=%0d, required 0 1", clear_fifos, req_ready);
        end
        tick();
        req_valid = 1'b0;
        drain_all(ok1);
        n_cmp++;
        if (!ok1) begin
            n_err++; $display("FAIL sw_drain: got inflight=%0d, required 0", inflight);
        end
    endtask

    task automatic test_cfg();
        bit ok;
        send(2'd2, 3'd3, 1'b1, ok);
        cfg_valid = 1'b1; cfg_rca_sel = 2'd2;
        #1;
        n_cmp++;
        if (!ok || cfg_ready !== 1'b0) begin
            n_err++; $display("FAIL cfg_stall: got ok=%0d cfg_ready=%0d, required 1 0", ok, cfg_ready);
        end
        cfg_rca_sel = 2'd3;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL cfg_other: got %0d, required 1", cfg_ready);
        end
        tick();
        cfg_rca_sel = 2'd2; fifo_populated = 1'b1; wb_ack = 1'b1;
        tick();
        fifo_populated = 1'b0; wb_ack = 1'b0;
        #1;
        n_cmp++;
        if (inflight !== 3'd0 || cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL cfg_grant: got inflight=%0d cfg_ready=%0d, required 0 1", inflight, cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        req_valid = 1'b1; req_rca_sel = 2'd2; req_id = 3'd4; req_fb = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++; $display("FAIL dirty_block: got %0d, required 0", req_ready);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b1) begin
            n_err++; $display("FAIL dirty_clear1: got %0d, required 1", clear_fifos);
        end
        tick();
        n_cmp++;
        if (clear_fifos !== 1'b1) begin
            n_err++; $display("FAIL dirty_clear2: got %0d, required 1", clear_fifos);
        end
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL dirty_run: got %0d, required 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        drain_all(ok);
    endtask

    task automatic test_wrap();
        bit ok1, ok2;
        send(2'd2, 3'd0, 1'b1, ok1);
        send(2'd2, 3'd1, 1'b0, ok2);
        fifo_populated = 1'b1; wb_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = 1'b1; req_rca_sel = 2'd2; req_id = 3'(k + 2); req_fb = 1'(k);
            #1;
            n_cmp++;
            if (req_ready !== 1'b1 || wb_committing !== 1'b1) begin
                n_err++; $display("FAIL wrap_both%0d: got rdy=%0d com=%0d, required 1 1", k, req_ready, wb_committing);
            end
            tick();
            n_cmp++;
            if (inflight !== 3'd2) begin
                n_err++; $display("FAIL wrap_inflight%0d: got %0d, required 2", k, inflight);
            end
        end
        req_valid = 1'b0;
        drain_all(ok1);
        n_cmp++;
        if (!ok1 || !ok2) begin
            n_err++; $display("FAIL wrap_drain: got inflight=%0d, required 0", inflight);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        for (int i = 0; i < 3; i++) send(2'd2, 3'(i + 1), 1'b0, ok);
        n_cmp++;
        if (inflight !== 3'd3) begin
            n_err++; $display("FAIL rst_setup: got inflight=%0d, required 3", inflight);
        end
        fifo_populated = 1'b1; rst = 1'b1;
        tick();
        sb.delete();
        n_cmp++;
        if (inflight !== 3'd0 || wb_done !== 1'b0 || clear_fifos !== 1'b1 ||
            buf_data_valid !== 1'b0 || currently_running_rca !== 2'd0) begin
            n_err++; $display("FAIL rst_mid: got inflight=%0d done=%0d clr=%0d bdv=%0d rca=%0d, required 0 0 1 0 0",
                              inflight, wb_done, clear_fifos, buf_data_valid, currently_running_rca);
        end
        rst = 1'b0; fifo_populated = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_switch();
        test_cfg();
        test_wrap();
        test_rst_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
